// File: rtl/tetris_drop_scheduler.sv
// Gravity and lock-delay scheduler: emits registered drop_tick / lock_req pulses
// from a level-dependent fall period, soft drop, pause and a move-resettable lock timer.
module tetris_drop_scheduler #(
  parameter int unsigned BASE_PERIOD = 60000000,
  parameter int unsigned LEVEL_STEP  = 5000000,
  parameter int unsigned MIN_PERIOD  = 6000000,
  parameter int unsigned SOFT_PERIOD = 5000000,
  parameter int unsigned LOCK_DELAY  = 30000000,
  parameter int unsigned MAX_RESETS  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pause,
  input  logic [3:0] level,
  input  logic       soft_drop,
  input  logic       hard_drop,
  input  logic       landed,
  input  logic       move_ack,
  output logic       drop_tick,
  output logic       lock_req,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFall = 2'd1,
    StLock = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fall_cnt_q, fall_cnt_d;
  logic [31:0] lock_cnt_q, lock_cnt_d;
  logic [31:0] reset_cnt_q, reset_cnt_d;
  logic        drop_tick_q, drop_tick_d;
  logic        lock_req_q, lock_req_d;

  logic [31:0] lvl_red, normal_period, eff_period;

  // Clamp before subtracting so high levels never wrap below the floor.
  always_comb begin
    lvl_red       = 32'(level) * LEVEL_STEP;
    normal_period = (lvl_red > BASE_PERIOD - MIN_PERIOD) ? MIN_PERIOD : BASE_PERIOD - lvl_red;
    eff_period    = (soft_drop && (SOFT_PERIOD < normal_period)) ? SOFT_PERIOD : normal_period;
  end

  always_comb begin
    state_d     = state_q;
    fall_cnt_d  = fall_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    reset_cnt_d = reset_cnt_q;
    drop_tick_d = 1'b0;
    lock_req_d  = 1'b0;

    if (!enable) begin
      state_d     = StIdle;
      fall_cnt_d  = '0;
      lock_cnt_d  = '0;
      reset_cnt_d = '0;
    end else if (!pause) begin
      case (state_q)
        StIdle: begin
          state_d     = StFall;
          fall_cnt_d  = '0;
          lock_cnt_d  = '0;
          reset_cnt_d = '0;
        end
        StFall: begin
          if (hard_drop) begin
            lock_req_d  = 1'b1;
            fall_cnt_d  = '0;
            lock_cnt_d  = '0;
            reset_cnt_d = '0;
          end else if (landed) begin
            state_d     = StLock;
            fall_cnt_d  = '0;
            lock_cnt_d  = '0;
            reset_cnt_d = '0;
          end else if (fall_cnt_q >= eff_period - 32'd1) begin
            // >= lets a period shortened mid-count fire immediately.
            drop_tick_d = 1'b1;
            fall_cnt_d  = '0;
          end else begin
            fall_cnt_d = fall_cnt_q + 32'd1;
          end
        end
        StLock: begin
          if (hard_drop || !landed) begin
            lock_req_d  = hard_drop;
            state_d     = StFall;
            fall_cnt_d  = '0;
            lock_cnt_d  = '0;
            reset_cnt_d = '0;
          end else if (move_ack && (reset_cnt_q < MAX_RESETS)) begin
            lock_cnt_d  = '0;
            reset_cnt_d = reset_cnt_q + 32'd1;
          end else if (lock_cnt_q >= LOCK_DELAY - 32'd1) begin
            lock_req_d  = 1'b1;
            state_d     = StFall;
            fall_cnt_d  = '0;
            lock_cnt_d  = '0;
            reset_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 32'd1;
          end
        end
        default: begin
          state_d     = StIdle;
          fall_cnt_d  = '0;
          lock_cnt_d  = '0;
          reset_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      fall_cnt_q  <= '0;
      lock_cnt_q  <= '0;
      reset_cnt_q <= '0;
      drop_tick_q <= 1'b0;
      lock_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fall_cnt_q  <= fall_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      reset_cnt_q <= reset_cnt_d;
      drop_tick_q <= drop_tick_d;
      lock_req_q  <= lock_req_d;
    end
  end

  assign drop_tick = drop_tick_q;
  assign lock_req  = lock_req_q;
  assign state     = state_q;

endmodule

// File: tb/tb_tetris_drop_scheduler.sv
// Scoreboard bench for tetris_drop_scheduler: stimulus queues expected pulses with
// their cycle numbers; a negedge monitor pops and compares every pulse seen.
module tb_tetris_drop_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, pause, soft_drop, hard_drop, landed, move_ack;
  logic [3:0] level;
  logic       drop_tick, lock_req;
  logic [1:0] state;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit is_lock;
    int cyc;
  } ev_t;

  ev_t exp_q[$];

  tetris_drop_scheduler #(
    .BASE_PERIOD(100),
    .LEVEL_STEP (10),
    .MIN_PERIOD (20),
    .SOFT_PERIOD(8),
    .LOCK_DELAY (30),
    .MAX_RESETS (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .pause    (pause),
    .level    (level),
    .soft_drop(soft_drop),
    .hard_drop(hard_drop),
    .landed   (landed),
    .move_ack (move_ack),
    .drop_tick(drop_tick),
    .lock_req (lock_req),
    .state    (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: flag expected pulses that never came, then match any pulse seen.
  always @(negedge clk) begin
    ev_t ev;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      ev = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_%s: no pulse by cycle %0d, required at cycle %0d",
               ev.is_lock ? "lock_req" : "drop_tick", cyc, ev.cyc);
    end
    if (drop_tick || lock_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cycle %0d drop_tick=%0b lock_req=%0b, required none",
                 cyc, drop_tick, lock_req);
      end else begin
        ev = exp_q.pop_front();
        if (ev.cyc != cyc || lock_req != ev.is_lock || drop_tick != !ev.is_lock) begin
          errors++;
          $display("FAIL pulse_match: cycle %0d drop_tick=%0b lock_req=%0b, required %s at cycle %0d",
                   cyc, drop_tick, lock_req, ev.is_lock ? "lock_req" : "drop_tick", ev.cyc);
        end
      end
    end
  end

  task automatic push_ev(input bit is_lock, input int c);
    ev_t ev;
    ev.is_lock = is_lock;
    ev.cyc     = c;
    exp_q.push_back(ev);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic check_eq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  // Clears the block via enable, then re-enables; e is the edge that enters FALL.
  task automatic start_fall(output int e);
    enable = 1'b0;
    step(2);
    enable = 1'b1;
    e = cyc + 1;
  endtask

  task automatic pulse_ack(input int sample_edge);
    wait_until(sample_edge - 1);
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, l, r;
    rst = 1'b0; enable = 1'b0; pause = 1'b0; soft_drop = 1'b0;
    hard_drop = 1'b0; landed = 1'b0; move_ack = 1'b0; level = 4'd0;

    // Reset state
    wait_until(3);
    check_eq("reset_state", int'(state), 0);
    check_eq("reset_drop_tick", int'(drop_tick), 0);
    check_eq("reset_lock_req", int'(lock_req), 0);
    rst = 1'b1;
    step(1);

    // Level 0: 100-cycle period
    start_fall(e);
    push_ev(0, e + 100); push_ev(0, e + 200); push_ev(0, e + 300);
    wait_until(e);
    check_eq("enter_fall_state", int'(state), 1);
    wait_until(e + 305);

    // Level 3: 70-cycle period
    level = 4'd3;
    start_fall(e);
    push_ev(0, e + 70); push_ev(0, e + 140);
    wait_until(e + 145);

    // Level 0 -> 9 at fall_cnt 50: fires next cycle, then every 20 (clamped)
    level = 4'd0;
    start_fall(e);
    wait_until(e + 50);
    level = 4'd9;
    push_ev(0, e + 51); push_ev(0, e + 71); push_ev(0, e + 91);
    wait_until(e + 95);

    // Soft drop: 8-cycle period, then back to 100 after release
    level = 4'd0;
    soft_drop = 1'b1;
    start_fall(e);
    push_ev(0, e + 8); push_ev(0, e + 16); push_ev(0, e + 24);
    wait_until(e + 24);
    soft_drop = 1'b0;
    push_ev(0, e + 124);
    wait_until(e + 130);

    // Landing: lock_req 30 cycles after entering LOCK, no drop_tick
    start_fall(e);
    wait_until(e + 10);
    landed = 1'b1;
    l = e + 11;
    push_ev(1, l + 30);
    wait_until(l);
    check_eq("enter_lock_state", int'(state), 2);
    wait_until(l + 30);
    landed = 1'b0;

    // Five move_acks at 10-cycle spacing: only three accepted
    start_fall(e);
    wait_until(e + 5);
    landed = 1'b1;
    l = e + 6;
    push_ev(1, l + 60);
    pulse_ack(l + 10); pulse_ack(l + 20); pulse_ack(l + 30);
    pulse_ack(l + 40); pulse_ack(l + 50);
    wait_until(l + 60);
    check_eq("after_lock_state", int'(state), 1);
    landed = 1'b0;

    // Slide off a ledge with a simultaneous move_ack: landed wins
    start_fall(e);
    wait_until(e + 5);
    landed = 1'b1;
    l = e + 6;
    wait_until(l + 5);
    landed = 1'b0;
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0;
    check_eq("slide_off_state", int'(state), 1);
    push_ev(0, l + 106);
    wait_until(l + 110);

    // Pause 40 cycles at fall_cnt 60: tick 40 cycles late
    start_fall(e);
    wait_until(e + 60);
    pause = 1'b1;
    wait_until(e + 100);
    check_eq("paused_state", int'(state), 1);
    pause = 1'b0;
    push_ev(0, e + 140);
    wait_until(e + 145);

    // Hard drop during LOCK: lock_req one cycle later, state FALL
    start_fall(e);
    wait_until(e + 5);
    landed = 1'b1;
    l = e + 6;
    wait_until(l + 10);
    hard_drop = 1'b1;
    push_ev(1, l + 11);
    step(1);
    check_eq("hard_drop_state", int'(state), 1);
    hard_drop = 1'b0;
    landed = 1'b0;

    // Reset at fall_cnt 90 discards the partial count
    start_fall(e);
    wait_until(e + 90);
    rst = 1'b0;
    step(1);
    check_eq("midreset_state", int'(state), 0);
    check_eq("midreset_drop_tick", int'(drop_tick), 0);
    check_eq("midreset_lock_req", int'(lock_req), 0);
    wait_until(e + 95);
    rst = 1'b1;
    r = cyc + 1;
    push_ev(0, r + 100);
    wait_until(r + 105);

    check_eq("pending_expected", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
